sender_frame_timer: RTL and testbench

Parametrised slot/frame timing generator for the sender datapath. Divides sysclk into slots and slots into frames, and raises per-channel one-cycle trigger pulses on programmable slots with per-channel frame decimation. Supports three external-sync modes with lock/loss status, plus a 1 Hz pulse and square wave. Generalised successor to the fixed 32-slot / 6k-3k-1k trigger timer.

---
 rtl/sender_timer_pkg.sv | 29 ++
 rtl/sender_ch_trig.sv | 43 ++++
 rtl/sender_frame_timer.sv | 150 +++++++++++++++
 tb/tb_sender_frame_timer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sender_timer_pkg.sv
// rtl/sender_timer_pkg.sv - sync mode encodings, default widths and clog2 for the sender frame timer
package sender_timer_pkg;

   typedef enum logic [1:0] {
      MODE_FREE     = 2'd0,
      MODE_HARD     = 2'd1,
      MODE_WIN      = 2'd2,
      MODE_FREE_ALT = 2'd3
   } sync_mode_e;

   localparam int DEF_CNT_W     = 11;
   localparam int DEF_NUM_SLOTS = 32;
   localparam int DEF_SLOT_W    = 5;
   localparam int DEF_NUM_CH    = 4;
   localparam int DEF_DEC_W     = 2;

   function automatic int clog2(input longint v);
      int     r;
      longint p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sender_ch_trig.sv
// rtl/sender_ch_trig.sv - one trigger channel: frame decimation counter and slot compare
// slot_tick/frame_tick/realign/slot_idx carry the values being registered in the top this edge.
module sender_ch_trig
   import sender_timer_pkg::*;
#(
   parameter int SLOT_W = DEF_SLOT_W,
   parameter int DEC_W  = DEF_DEC_W
)
(
   input  logic              sysclk,
   input  logic              rst,
   input  logic              slot_tick,
   input  logic              frame_tick,
   input  logic              realign,
   input  logic [SLOT_W-1:0] slot_idx,
   input  logic [SLOT_W-1:0] ch_slot,
   input  logic [DEC_W-1:0]  ch_dec,
   output logic              ch_trig
);

   logic [DEC_W-1:0] dec_cnt;
   logic [DEC_W-1:0] dec_nxt;

   // The whole new frame, slot 0 included, sees the advanced decimation count.
   always_comb begin
      dec_nxt = dec_cnt;
      if (realign)
         dec_nxt = '0;
      else if (frame_tick)
         dec_nxt = (dec_cnt >= ch_dec) ? '0 : dec_cnt + DEC_W'(1);
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         dec_cnt <= '0;
         ch_trig <= 1'b0;
      end else begin
         dec_cnt <= dec_nxt;
         ch_trig <= slot_tick && (slot_idx == ch_slot) && (dec_nxt == '0);
      end
   end

endmodule

// File: rtl/sender_frame_timer.sv
// rtl/sender_frame_timer.sv - slot/frame timing generator with external sync, channel triggers and 1 Hz outputs
module sender_frame_timer
   import sender_timer_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int SLOT_W    = DEF_SLOT_W,
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int DEC_W     = DEF_DEC_W,
   parameter int SYNC_WIN  = 8,
   parameter int SYNC_TO   = 4,
   parameter int SEC_DIV   = 125000000
)
(
   input  logic                     sysclk,
   input  logic                     rst,
   input  logic                     ex_sync,
   input  logic [1:0]               sync_mode,
   input  logic [CNT_W-1:0]         slot_div,
   input  logic [NUM_CH*SLOT_W-1:0] ch_slot,
   input  logic [NUM_CH*DEC_W-1:0]  ch_dec,
   output logic                     slot_tick,
   output logic                     frame_tick,
   output logic [SLOT_W-1:0]        slot_idx,
   output logic [NUM_CH-1:0]        ch_trig,
   output logic                     sync_locked,
   output logic                     sync_lost,
   output logic                     sec_p,
   output logic                     sec
);

   localparam int SEC_W  = (clog2(SEC_DIV) < 1) ? 1 : clog2(SEC_DIV);
   localparam int LOSS_W = clog2(SYNC_TO + 1);
   localparam int CW1    = CNT_W + 1;

   sync_mode_e       mode;
   logic             sync_a, sync_b, sync_c, egr;
   logic [CNT_W-1:0] slot_cnt, div_act, div_in, cnt_nxt;
   logic [SLOT_W-1:0] idx_nxt;
   logic             tick_nxt, frame_nxt, realign, in_win, sync_on;
   logic [LOSS_W-1:0] loss_cnt;
   logic [SEC_W-1:0] sec_cnt;

   assign mode    = sync_mode_e'(sync_mode);
   assign sync_on = (mode == MODE_HARD) || (mode == MODE_WIN);
   assign div_in  = (slot_div < CNT_W'(2)) ? CNT_W'(2) : slot_div;

   // Tolerated edge positions: early in slot 0 or late in the last slot.
   assign in_win = ((slot_idx == '0) && ({1'b0, slot_cnt} <= CW1'(SYNC_WIN)))
                || ((slot_idx == SLOT_W'(NUM_SLOTS - 1))
                    && (({1'b0, slot_cnt} + CW1'(SYNC_WIN + 1)) >= {1'b0, div_act}));

   assign realign = egr && ((mode == MODE_HARD) || ((mode == MODE_WIN) && !in_win));

   always_comb begin
      cnt_nxt   = slot_cnt + CNT_W'(1);
      idx_nxt   = slot_idx;
      tick_nxt  = 1'b0;
      frame_nxt = 1'b0;
      if (realign) begin
         cnt_nxt   = '0;
         idx_nxt   = '0;
         tick_nxt  = 1'b1;
         frame_nxt = 1'b1;
      end else if (slot_cnt >= div_act - CNT_W'(1)) begin
         cnt_nxt  = '0;
         tick_nxt = 1'b1;
         if (slot_idx >= SLOT_W'(NUM_SLOTS - 1)) begin
            idx_nxt   = '0;
            frame_nxt = 1'b1;
         end else begin
            idx_nxt = slot_idx + SLOT_W'(1);
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         sync_a     <= 1'b0;
         sync_b     <= 1'b0;
         sync_c     <= 1'b0;
         egr        <= 1'b0;
         slot_cnt   <= '0;
         slot_idx   <= '0;
         slot_tick  <= 1'b0;
         frame_tick <= 1'b0;
         div_act    <= div_in;
      end else begin
         sync_a     <= ex_sync;
         sync_b     <= sync_a;
         sync_c     <= sync_b;
         egr        <= sync_b & ~sync_c;
         slot_cnt   <= cnt_nxt;
         slot_idx   <= idx_nxt;
         slot_tick  <= tick_nxt;
         frame_tick <= frame_nxt;
         if (frame_tick)
            div_act <= div_in;
      end
   end

   // A sync edge outranks the frame count it coincides with, including its own realign tick.
   always_ff @(posedge sysclk) begin
      if (rst || !sync_on) begin
         loss_cnt    <= '0;
         sync_locked <= 1'b0;
         sync_lost   <= 1'b0;
      end else if (egr) begin
         loss_cnt    <= '0;
         sync_lost   <= 1'b0;
         sync_locked <= (mode == MODE_HARD) || in_win;
      end else if (frame_nxt && (loss_cnt < LOSS_W'(SYNC_TO))) begin
         loss_cnt <= loss_cnt + LOSS_W'(1);
         if (loss_cnt == LOSS_W'(SYNC_TO - 1)) begin
            sync_lost   <= 1'b1;
            sync_locked <= 1'b0;
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         sec_cnt <= '0;
         sec_p   <= 1'b0;
      end else begin
         sec_p   <= (sec_cnt == SEC_W'(SEC_DIV - 1));
         sec_cnt <= (sec_cnt == SEC_W'(SEC_DIV - 1)) ? '0 : sec_cnt + SEC_W'(1);
      end
   end

   assign sec = (sec_cnt >= SEC_W'(SEC_DIV / 2));

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      sender_ch_trig #(
         .SLOT_W (SLOT_W),
         .DEC_W  (DEC_W)
      ) u_ch (
         .sysclk     (sysclk),
         .rst        (rst),
         .slot_tick  (tick_nxt),
         .frame_tick (frame_nxt),
         .realign    (realign),
         .slot_idx   (idx_nxt),
         .ch_slot    (ch_slot[k*SLOT_W +: SLOT_W]),
         .ch_dec     (ch_dec[k*DEC_W +: DEC_W]),
         .ch_trig    (ch_trig[k])
      );
   end

endmodule

// File: tb/tb_sender_frame_timer.sv
// tb/tb_sender_frame_timer.sv - self-checking bench for sender_frame_timer with an elapsed-time reference model
module tb_sender_frame_timer;

   localparam int CNT_W     = 11;
   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 3;
   localparam int NUM_CH    = 4;
   localparam int DEC_W     = 2;
   localparam int SYNC_WIN  = 2;
   localparam int SYNC_TO   = 4;
   localparam int SEC_DIV   = 100;

   logic                     sysclk;
   logic                     rst;
   logic                     ex_sync;
   logic [1:0]               sync_mode;
   logic [CNT_W-1:0]         slot_div;
   logic [NUM_CH*SLOT_W-1:0] ch_slot;
   logic [NUM_CH*DEC_W-1:0]  ch_dec;
   logic                     slot_tick, frame_tick, sync_locked, sync_lost, sec_p, sec;
   logic [SLOT_W-1:0]        slot_idx;
   logic [NUM_CH-1:0]        ch_trig;

   sender_frame_timer #(
      .CNT_W(CNT_W), .NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W), .NUM_CH(NUM_CH), .DEC_W(DEC_W),
      .SYNC_WIN(SYNC_WIN), .SYNC_TO(SYNC_TO), .SEC_DIV(SEC_DIV)
   ) dut (
      .sysclk(sysclk), .rst(rst), .ex_sync(ex_sync), .sync_mode(sync_mode), .slot_div(slot_div),
      .ch_slot(ch_slot), .ch_dec(ch_dec), .slot_tick(slot_tick), .frame_tick(frame_tick),
      .slot_idx(slot_idx), .ch_trig(ch_trig), .sync_locked(sync_locked), .sync_lost(sync_lost),
      .sec_p(sec_p), .sec(sec)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: positions derived from elapsed cycles since the current frame start.
   int m_abs = 0, frame_start = 0, frame_div = 2, fnum = 0, sec_start = 0, nofr = 0;
   bit need_div = 0;
   bit xh [4];
   bit e_tick, e_frame, e_locked, e_lost, e_secp, e_sec;
   int e_idx, e_cnt;
   logic [NUM_CH-1:0] e_trig;

   function automatic int div_of(input int d);
      return (d < 2) ? 2 : d;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_edge();
      bit egr_prev, inwin, rl, on;
      int el, sl, dc, md;
      m_abs++;
      egr_prev = xh[2] & ~xh[3];
      for (int i = 3; i > 0; i--) xh[i] = xh[i-1];
      xh[0] = ex_sync;
      if (rst) begin
         for (int i = 0; i < 4; i++) xh[i] = 1'b0;
         frame_start = m_abs; fnum = 0; frame_div = div_of(int'(slot_div));
         sec_start = m_abs; nofr = 0; need_div = 0;
         e_tick = 0; e_frame = 0; e_locked = 0; e_lost = 0; e_secp = 0; e_sec = 0;
         e_idx = 0; e_cnt = 0; e_trig = '0;
         return;
      end
      if (need_div) frame_div = div_of(int'(slot_div));
      md = int'(sync_mode);
      on = (md == 1) || (md == 2);
      inwin = ((e_idx == 0) && (e_cnt <= SYNC_WIN))
           || ((e_idx == NUM_SLOTS - 1) && (e_cnt >= frame_div - 1 - SYNC_WIN));
      rl = egr_prev && ((md == 1) || ((md == 2) && !inwin));
      e_tick = 0; e_frame = 0; e_trig = '0;
      if (rl) begin
         frame_start = m_abs; fnum = 0;
         e_tick = 1; e_frame = 1; e_idx = 0; e_cnt = 0;
      end else begin
         el = m_abs - frame_start;
         if (el == NUM_SLOTS * frame_div) begin
            frame_start = m_abs; fnum++; el = 0; e_tick = 1; e_frame = 1;
         end else begin
            e_tick = (el % frame_div) == 0;
         end
         e_idx = el / frame_div;
         e_cnt = el % frame_div;
      end
      need_div = e_frame;
      if (e_tick)
         for (int k = 0; k < NUM_CH; k++) begin
            sl = int'(ch_slot[k*SLOT_W +: SLOT_W]);
            dc = int'(ch_dec[k*DEC_W +: DEC_W]);
            e_trig[k] = (sl == e_idx) && ((fnum % (dc + 1)) == 0);
         end
      if (!on) begin
         e_locked = 0; e_lost = 0; nofr = 0;
      end else if (egr_prev) begin
         nofr = 0; e_lost = 0; e_locked = (md == 1) || inwin;
      end else if (e_frame) begin
         if (nofr < SYNC_TO) nofr++;
         if (nofr >= SYNC_TO) begin
            e_lost = 1; e_locked = 0;
         end
      end
      el = m_abs - sec_start;
      e_secp = (el % SEC_DIV) == 0;
      e_sec  = (el % SEC_DIV) >= SEC_DIV / 2;
   endtask

   task automatic compare();
      chk("slot_tick", slot_tick, e_tick);
      chk("frame_tick", frame_tick, e_frame);
      chk("slot_idx", slot_idx, e_idx);
      chk("ch_trig", ch_trig, e_trig);
      chk("sync_locked", sync_locked, e_locked);
      chk("sync_lost", sync_lost, e_lost);
      chk("sec_p", sec_p, e_secp);
      chk("sec", sec, e_sec);
   endtask

   task automatic step();
      @(posedge sysclk);
      if (!rst) cyc++;
      model_edge();
      @(negedge sysclk);
      compare();
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (4) step();
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ex_sync = 1'b0; sync_mode = 2'd0; slot_div = 11'd10;
      ch_slot = {3'd1, 3'd5, 3'd0, 3'd2};
      ch_dec  = {2'd3, 2'd0, 2'd1, 2'd0};
      do_reset();
      chk("lit_rst_idx", slot_idx, 0);
      chk("lit_rst_tick", slot_tick, 0);
      chk("lit_rst_trig", ch_trig, 0);
      chk("lit_rst_sec", sec, 0);

      run_to(9);   chk("lit_c9_tick", slot_tick, 0);
      run_to(10);  chk("lit_c10_tick", slot_tick, 1); chk("lit_c10_idx", slot_idx, 1);
                   chk("lit_c10_trig", ch_trig, 4'b1000);
      run_to(20);  chk("lit_c20_idx", slot_idx, 2); chk("lit_c20_trig", ch_trig, 4'b0001);
      run_to(30);  chk("lit_c30_idx", slot_idx, 3);
      run_to(40);  chk("lit_c40_frame", frame_tick, 1); chk("lit_c40_idx", slot_idx, 0);
                   chk("lit_c40_trig", ch_trig, 4'b0000);
      run_to(49);  chk("lit_c49_sec", sec, 0);
      run_to(50);  chk("lit_c50_sec", sec, 1); chk("lit_c50_trig", ch_trig, 4'b0000);
      run_to(80);  chk("lit_c80_frame", frame_tick, 1); chk("lit_c80_trig", ch_trig, 4'b0010);
      run_to(99);  chk("lit_c99_sec", sec, 1); chk("lit_c99_secp", sec_p, 0);
      run_to(100); chk("lit_c100_secp", sec_p, 1); chk("lit_c100_sec", sec, 0);
      run_to(170); chk("lit_c170_trig", ch_trig, 4'b1000);

      run_to(201); sync_mode = 2'd1;
      run_to(224); chk("lit_c224_idx", slot_idx, 2); ex_sync = 1'b1;
      run_to(227); chk("lit_c227_frame", frame_tick, 0);
      run_to(228); chk("lit_c228_frame", frame_tick, 1); chk("lit_c228_idx", slot_idx, 0);
                   chk("lit_c228_locked", sync_locked, 1); chk("lit_c228_trig", ch_trig, 4'b0010);
      run_to(237); chk("lit_c237_tick", slot_tick, 0);
      run_to(238); chk("lit_c238_tick", slot_tick, 1); chk("lit_c238_trig", ch_trig, 4'b1000);
      run_to(240); ex_sync = 1'b0;

      run_to(348); chk("lit_c348_lost", sync_lost, 0); chk("lit_c348_locked", sync_locked, 1);
      run_to(387); chk("lit_c387_lost", sync_lost, 0);
      run_to(388); chk("lit_c388_lost", sync_lost, 1); chk("lit_c388_locked", sync_locked, 0);
      run_to(400); ex_sync = 1'b1;
      run_to(404); chk("lit_c404_lost", sync_lost, 0); chk("lit_c404_locked", sync_locked, 1);
                   chk("lit_c404_frame", frame_tick, 1);

      run_to(410); ex_sync = 1'b0; sync_mode = 2'd2;
      run_to(413); ex_sync = 1'b1;
      run_to(416); chk("lit_c416_idx", slot_idx, 1);
      run_to(417); chk("lit_c417_frame", frame_tick, 1); chk("lit_c417_locked", sync_locked, 0);
      run_to(420); ex_sync = 1'b0;
      run_to(452); ex_sync = 1'b1;
      run_to(456); chk("lit_c456_locked", sync_locked, 1); chk("lit_c456_frame", frame_tick, 0);
                   chk("lit_c456_idx", slot_idx, 3);
      run_to(457); chk("lit_c457_frame", frame_tick, 1);
      run_to(460); ex_sync = 1'b0;

      run_to(465); sync_mode = 2'd0;
      run_to(466); chk("lit_c466_locked", sync_locked, 0);
      run_to(470); slot_div = 11'd20;
      run_to(487); chk("lit_c487_tick", slot_tick, 1);
      run_to(497); chk("lit_c497_frame", frame_tick, 1);
      run_to(507); chk("lit_c507_tick", slot_tick, 0);
      run_to(517); chk("lit_c517_tick", slot_tick, 1); chk("lit_c517_idx", slot_idx, 1);
      run_to(577); chk("lit_c577_frame", frame_tick, 1);
      run_to(580); slot_div = 11'd1;
      run_to(657); chk("lit_c657_frame", frame_tick, 1);
      run_to(658); chk("lit_c658_tick", slot_tick, 0);
      run_to(659); chk("lit_c659_tick", slot_tick, 1); chk("lit_c659_idx", slot_idx, 1);
      run_to(665); chk("lit_c665_frame", frame_tick, 1);
      run_to(700); chk("lit_c700_secp", sec_p, 1);

      run_to(703); slot_div = 11'd10; sync_mode = 2'd1; rst = 1'b1;
      step();
      chk("lit_mid_rst_idx", slot_idx, 0);
      chk("lit_mid_rst_sec", sec, 0);
      do_reset();
      run_to(10);  chk("lit_rr_c10_tick", slot_tick, 1);
      run_to(45);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
